// File: rtl/ks_sub_pipe_64_pkg.sv
// Shared Kogge-Stone definitions for the adder/subtractor datapath library.
package ks_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SPLIT = 3;
    localparam int LEVELS    = $clog2(DEF_WIDTH);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/ks_sub_pipe_64_if.sv
// Operand/result handshake bundle for ks_sub_pipe_64.
interface ks_sub_pipe_64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/ks_sub_pipe_64_prefix.sv
// One combinational Kogge-Stone prefix level at a fixed combine distance.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIST  = 1
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    always_comb begin
        o_gp = i_gp;
        for (int i = DIST; i < WIDTH; i++) begin
            o_gp[i].g = i_gp[i].g | (i_gp[i].p & i_gp[i-DIST].g);
            o_gp[i].p = i_gp[i].p & i_gp[i-DIST].p;
        end
    end

endmodule

// File: rtl/ks_sub_pipe_64.sv
// Three-stage Kogge-Stone subtractor (a - b - bin) with valid/ready flow control.
module ks_sub_pipe_64
    import ks_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPLIT = DEF_SPLIT
) (
    input  logic             clk,
    input  logic             rst,
    ks_sub_pipe_64_if.slave  bus
);

    localparam int LV = $clog2(WIDTH);

    logic             r_v1, r_v2, r_v3;
    logic             w_rdy1, w_rdy2, w_rdy3;

    logic [WIDTH-1:0] r_a, r_nb;
    logic             r_c0;

    gp_t  [WIDTH-1:0] r_gp;
    logic [WIDTH-1:0] r_p;
    logic             r_c0_s2;

    logic [WIDTH-1:0] r_diff;
    logic             r_bout, r_ovf, r_zero;

    logic [WIDTH-1:0] w_g0, w_p0;
    gp_t  [WIDTH-1:0] w_gp0;
    gp_t  [WIDTH-1:0] w_s2 [SPLIT+1];
    gp_t  [WIDTH-1:0] w_s3 [LV-SPLIT+1];
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_diff;

    assign w_rdy3       = !r_v3 || bus.out_ready;
    assign w_rdy2       = !r_v2 || w_rdy3;
    assign w_rdy1       = !r_v1 || w_rdy2;
    assign bus.in_ready = w_rdy1;

    assign w_g0 = r_a & r_nb;
    assign w_p0 = r_a ^ r_nb;

    // Carry-in folded into bit 0's generate so the prefix tree yields c[i+1] directly.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gp0[i] = '{g: w_g0[i], p: w_p0[i]};
        end
        w_gp0[0].g = w_g0[0] | (w_p0[0] & r_c0);
    end

    assign w_s2[0] = w_gp0;
    for (genvar l = 0; l < SPLIT; l++) begin : g_s2_lvl
        ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << l)) u_lvl (
            .i_gp (w_s2[l]),
            .o_gp (w_s2[l+1])
        );
    end

    assign w_s3[0] = r_gp;
    for (genvar l = SPLIT; l < LV; l++) begin : g_s3_lvl
        ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << l)) u_lvl (
            .i_gp (w_s3[l-SPLIT]),
            .o_gp (w_s3[l-SPLIT+1])
        );
    end

    always_comb begin
        w_c[0] = r_c0_s2;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_s3[LV-SPLIT][i].g;
        end
    end

    assign w_diff = r_p ^ w_c[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_a  <= '0;
            r_nb <= '0;
            r_c0 <= 1'b0;
        end else if (w_rdy1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a  <= bus.a;
                r_nb <= ~bus.b;
                r_c0 <= !bus.bin;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_gp    <= '0;
            r_p     <= '0;
            r_c0_s2 <= 1'b0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_gp    <= w_s2[SPLIT];
                r_p     <= w_p0;
                r_c0_s2 <= r_c0;
            end
        end
    end

    // Overflow is carry-into-MSB xor carry-out, equivalent to the operand-sign rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_diff <= w_diff;
                r_bout <= !w_c[WIDTH];
                r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
                r_zero <= (w_diff == '0);
            end
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_ks_sub_pipe_64.sv
// Directed and random checks of ks_sub_pipe_64 against a behavioural subtract model.
module tb_ks_sub_pipe_64;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ks_sub_pipe_64_if #(.WIDTH(W)) bus ();

    ks_sub_pipe_64 #(.WIDTH(W), .SPLIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_mis = 0;
    int            n_pop = 0;
    logic [127:0]  q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [63:0] d, input logic bo, input logic ov, input logic z);
        return {61'd0, bo, ov, z, d};
    endfunction

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input logic bin);
        logic [64:0] t;
        logic [63:0] d;
        logic        ov;
        t  = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        d  = t[63:0];
        ov = (a[63] != b[63]) && (d[63] != a[63]);
        return pack(d, t[64], ov, d == 64'd0);
    endfunction

    function automatic logic [127:0] dut_res();
        return pack(bus.diff, bus.bout, bus.ovf, bus.zero);
    endfunction

    // Observe handshakes mid-cycle, then advance one edge.
    task automatic cycle(output logic fin);
        logic fout;
        @(negedge clk);
        fin  = bus.in_valid && bus.in_ready;
        fout = bus.out_valid && bus.out_ready;
        if (fout) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 128'(fout), 128'(0));
            end else begin
                chk("beat_result", dut_res(), q.pop_front());
                n_pop++;
            end
        end
        if (fin) q.push_back(model(bus.a, bus.b, bus.bin));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b, input logic bin,
                            input logic [63:0] ed, input logic ebo, input logic eov, input logic ez);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        #1;
        chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_valid_t"}, 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1;
        chk({tag, "_valid_t1"}, 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1;
        chk({tag, "_valid_t2"}, 128'(bus.out_valid), 128'(1));
        chk({tag, "_result"}, dut_res(), pack(ed, ebo, eov, ez));
        @(posedge clk); #1;
        chk({tag, "_drained"}, 128'(bus.out_valid), 128'(0));
    endtask

    task automatic set_beat(input int k);
        bus.in_valid = 1'b1;
        bus.a        = 64'(k) * 64'd1000 + 64'd7;
        bus.b        = 64'(k);
        bus.bin      = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fin;
        int   k;
        int   start_pop;
        int   cyc;
        int   sent;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;

        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_outputs", dut_res(), 128'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));

        directed("basic",   64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
        directed("wrap",    64'd0,  64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        directed("zero",    64'd5,  64'd4, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
        directed("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        directed("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        directed("full_borrow", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);

        // Backpressure: six beats, sink stalls from the second cycle.
        start_pop     = n_pop;
        bus.out_ready = 1'b1;
        set_beat(1);
        cycle(fin);
        bus.out_ready = 1'b0;
        set_beat(2);
        #1;
        chk("bp_ready_after_1", 128'(bus.in_ready), 128'(1));
        cycle(fin);
        set_beat(3);
        #1;
        chk("bp_ready_after_2", 128'(bus.in_ready), 128'(1));
        cycle(fin);
        set_beat(4);
        #1;
        chk("bp_ready_after_3", 128'(bus.in_ready), 128'(0));
        for (int i = 0; i < 3; i++) begin
            cycle(fin);
            chk("bp_hold_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_hold_result", dut_res(), model(64'd1007, 64'd1, 1'b0));
            chk("bp_hold_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        k   = 4;
        cyc = 0;
        while ((n_pop - start_pop) < 6 && cyc < 40) begin
            cycle(fin);
            cyc++;
            if (fin) begin
                k++;
                if (k <= 6) set_beat(k);
                else bus.in_valid = 1'b0;
            end
        end
        chk("bp_drained_count", 128'(n_pop - start_pop), 128'(6));
        chk("bp_drain_cycles", 128'(cyc), 128'(6));

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 64'd50;
        bus.b         = 64'd8;
        bus.bin       = 1'b0;
        cycle(fin);
        bus.a = 64'd70;
        cycle(fin);
        bus.in_valid = 1'b0;
        cycle(fin);
        chk("rst_pre_valid", 128'(bus.out_valid), 128'(1));
        chk("rst_pre_result", dut_res(), model(64'd50, 64'd8, 1'b0));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_async_outputs", dut_res(), 128'(0));
        q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(fin);
            chk("rst_no_stale", 128'(bus.out_valid), 128'(0));
        end

        // Random traffic with random stalls on both sides.
        start_pop    = n_pop;
        sent         = 0;
        cyc          = 0;
        bus.in_valid = 1'b0;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            if (!bus.in_valid) begin
                if (sent < 10000 && $urandom_range(0, 9) < 7) begin
                    bus.in_valid = 1'b1;
                    bus.a        = {$urandom, $urandom};
                    bus.b        = ($urandom_range(0, 7) == 0) ? bus.a : {$urandom, $urandom};
                    bus.bin      = 1'($urandom_range(0, 1));
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle(fin);
            cyc++;
            if (fin) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        chk("rand_sent", 128'(sent), 128'(10000));
        chk("rand_received", 128'(n_pop - start_pop), 128'(10000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
